// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
// Shared types and default constants for the ping-pong buffer read engine.
//   rd_state_t    : reader sequencing states (IDLE / READ / DRAIN)
//   PP_DATA_W     : default read-data / stream width
//   PP_ADDR_W     : default read-address width
//   PP_FRAME_LEN  : default words per frame
//   PP_FIFO_DEPTH : default output FIFO depth
// -----------------------------------------------------------------------------
package pingpong_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   localparam int unsigned PP_DATA_W     = 32;
   localparam int unsigned PP_ADDR_W     = 8;
   localparam int unsigned PP_FRAME_LEN  = 256;
   localparam int unsigned PP_FIFO_DEPTH = 2;

endpackage

// File: rtl/pingpong_rd_fifo.sv
// -----------------------------------------------------------------------------
// pingpong_rd_fifo
// Small synchronous FIFO holding stream words plus their end-of-frame tag.
// Head entry is presented combinationally (first-word fall-through).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (flushes contents)
//   wr_en_i     : push wr_data_i / wr_last_i
//   rd_en_i     : pop head when non-empty
//   rd_data_o   : head data,  rd_last_o : head end-of-frame tag
//   rd_valid_o  : FIFO non-empty, count_o : number of stored entries
// -----------------------------------------------------------------------------
module pingpong_rd_fifo
   import pingpong_pkg::*;
#(
   parameter int unsigned DATA_W = PP_DATA_W,
   parameter int unsigned DEPTH  = PP_FIFO_DEPTH,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_last_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_last_o,
   output logic              rd_valid_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  last_q;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_wr, do_rd, full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign do_rd = rd_en_i && (count_q != '0);
   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   assign do_wr = wr_en_i && (!full || do_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
         last_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            data_q[wr_ptr_q] <= wr_data_i;
            last_q[wr_ptr_q] <= wr_last_i;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data_o  = data_q[rd_ptr_q];
   assign rd_last_o  = last_q[rd_ptr_q];
   assign rd_valid_o = (count_q != '0);
   assign count_o    = count_q;

endmodule

// File: rtl/pingpong_reader.sv
// -----------------------------------------------------------------------------
// pingpong_reader
// Read-side engine for the ping-pong sample buffer. After the buffer's swap
// strobe it sweeps the read port through one frame, absorbs the one-cycle RAM
// read latency through a credit-controlled output FIFO and streams the words
// out as valid/ready with an end-of-frame marker.
// Optional feature macro: PINGPONG_READER_OVERRUN_DET_EN
//   defined   : err_overrun latches a swap strobe seen mid-frame (reset clears)
//   undefined : err_overrun tied low; stray strobes are still ignored
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   good_to_go   : one-cycle strobe, read bank has just swapped
//   r_addr       : registered read address to the buffer
//   r_q          : read data, valid the cycle after r_addr
//   read_done    : registered, high while no more reads are needed
//   m_data/m_valid/m_ready/m_last : output stream, m_last on word FRAME_LEN-1
//   err_overrun  : sticky mid-frame swap flag
// -----------------------------------------------------------------------------
module pingpong_reader
   import pingpong_pkg::*;
#(
   parameter int unsigned DATA_W     = PP_DATA_W,
   parameter int unsigned ADDR_W     = PP_ADDR_W,
   parameter int unsigned FRAME_LEN  = PP_FRAME_LEN,
   parameter int unsigned FIFO_DEPTH = PP_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              good_to_go,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_q,
   output logic              read_done,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              err_overrun
);

   localparam int unsigned IW    = ADDR_W + 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW    = CNT_W + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IW-1:0]     issue_cnt_q, issue_cnt_d;
   logic              in_flight_q, in_flight_last_q, read_done_q;
   logic              issue, beat;
   logic              fifo_valid, fifo_last;
   logic [CNT_W-1:0]  fifo_count;
   logic [OW-1:0]     occupancy, credit_lim;

   assign beat = fifo_valid & m_ready;

   // Credit test (fifo_count + in_flight - beat) < FIFO_DEPTH, rearranged so
   // the subtraction cannot underflow.
   assign occupancy  = {1'b0, fifo_count} + OW'(in_flight_q);
   assign credit_lim = OW'(FIFO_DEPTH) + OW'(beat);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_cnt_d = issue_cnt_q;
      issue       = 1'b0;
      case (state_q)
         IDLE: begin
            if (good_to_go) begin
               state_d     = READ;
               addr_d      = '0;
               issue_cnt_d = '0;
            end
         end
         READ: begin
            if (occupancy < credit_lim) begin
               issue       = 1'b1;
               issue_cnt_d = issue_cnt_q + 1'b1;
               // The final issue leaves the address on the last word so the
               // counter never wraps inside a frame.
               if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
               else                         addr_d  = addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (beat && fifo_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         addr_q           <= '0;
         issue_cnt_q      <= '0;
         in_flight_q      <= 1'b0;
         in_flight_last_q <= 1'b0;
         read_done_q      <= 1'b1;
      end else begin
         state_q          <= state_d;
         addr_q           <= addr_d;
         issue_cnt_q      <= issue_cnt_d;
         in_flight_q      <= issue;
         in_flight_last_q <= issue && (issue_cnt_q == LAST_IDX);
         read_done_q      <= (state_d == IDLE);
      end
   end

   pingpong_rd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (in_flight_q),
      .wr_data_i  (r_q),
      .wr_last_i  (in_flight_last_q),
      .rd_en_i    (m_ready),
      .rd_data_o  (m_data),
      .rd_last_o  (fifo_last),
      .rd_valid_o (fifo_valid),
      .count_o    (fifo_count)
   );

   assign r_addr    = addr_q;
   assign read_done = read_done_q;
   assign m_valid   = fifo_valid;
   assign m_last    = fifo_valid & fifo_last;

`ifdef PINGPONG_READER_OVERRUN_DET_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           err_q <= 1'b0;
      else if (good_to_go && state_q != IDLE) err_q <= 1'b1;
   end
   assign err_overrun = err_q;
`else
   assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_reader.sv
// -----------------------------------------------------------------------------
// tb_pingpong_reader
// Scoreboard bench: stimulus pushes the expected frame words into queues when
// it issues a swap strobe; independent monitors pop and compare on each beat.
// Instance A uses the default 256-word frame, instance B a 4-word frame fed by
// a two-bank ping-pong buffer model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pingpong_reader;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int FL  = 256;
   localparam int FLB = 4;

`ifdef PINGPONG_READER_OVERRUN_DET_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   typedef struct packed {logic [DW-1:0] d; logic l;} exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          gtg_a = 1'b0, mready_a = 1'b1;
   logic [AW-1:0] raddr_a;
   logic [DW-1:0] rq_a = '0, mdata_a;
   logic          rdone_a, mvalid_a, mlast_a, err_a;

   logic          gtg_b = 1'b0, mready_b = 1'b1;
   logic [AW-1:0] raddr_b;
   logic [DW-1:0] rq_b = '0, mdata_b;
   logic          rdone_b, mvalid_b, mlast_b, err_b;

   pingpong_reader u_dut_a (
      .clk(clk), .rst_n(rst_n), .good_to_go(gtg_a), .r_addr(raddr_a), .r_q(rq_a),
      .read_done(rdone_a), .m_data(mdata_a), .m_valid(mvalid_a), .m_ready(mready_a),
      .m_last(mlast_a), .err_overrun(err_a));

   pingpong_reader #(.FRAME_LEN(FLB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .good_to_go(gtg_b), .r_addr(raddr_b), .r_q(rq_b),
      .read_done(rdone_b), .m_data(mdata_b), .m_valid(mvalid_b), .m_ready(mready_b),
      .m_last(mlast_b), .err_overrun(err_b));

   // Buffer models: registered read, data one cycle after the address.
   logic [DW-1:0] mem_a [FL];
   logic [DW-1:0] bank_b [2][FLB];
   int            rd_sel_b = 1;
   always @(posedge clk) rq_a <= mem_a[raddr_a];
   always @(posedge clk) rq_b <= bank_b[rd_sel_b][raddr_b[1:0]];

   exp_t qa[$], qb[$];
   int   n_checks = 0, n_fail = 0;
   int   ready_mode_a = 0, ready_mode_b = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ready drivers: held high (mode 0) or random 50% (mode 1).
   initial forever begin
      @(posedge clk); #1;
      mready_a = (ready_mode_a == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mready_b = (ready_mode_b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   // Monitor A
   int            beats_a = 0, total_a = 0;
   logic          stall_a = 1'b0, held_l_a = 1'b0;
   logic [DW-1:0] held_d_a = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         beats_a = 0;
         stall_a = 1'b0;
      end else begin
         if (stall_a) begin
            chk("a_stall_valid", mvalid_a, 1'b1);
            chk("a_stall_data", mdata_a, held_d_a);
            chk("a_stall_last", mlast_a, held_l_a);
         end
         if (!rdone_a) chk("a_raddr_lead", (int'(raddr_a) <= beats_a + 2), 1'b1);
         if (mvalid_a && mready_a) begin
            if (qa.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_unexpected_beat: got data %0h, expected no beat", mdata_a);
            end else begin
               e = qa.pop_front();
               chk("a_beat_data", mdata_a, e.d);
               chk("a_beat_last", mlast_a, e.l);
            end
            beats_a = mlast_a ? 0 : beats_a + 1;
            total_a++;
         end
         stall_a  = mvalid_a && !mready_a;
         held_d_a = mdata_a;
         held_l_a = mlast_a;
      end
   end

   // Monitor B
   int         beats_b = 0;
   logic [7:0] last_pos_b = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (mvalid_b) chk("b_read_done_low", rdone_b, 1'b0);
         if (mvalid_b && mready_b) begin
            if (qb.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL b_unexpected_beat: got data %0h, expected no beat", mdata_b);
            end else begin
               e = qb.pop_front();
               chk("b_beat_data", mdata_b, e.d);
               chk("b_beat_last", mlast_b, e.l);
            end
            if (mlast_b && beats_b < 8) last_pos_b[beats_b] = 1'b1;
            beats_b++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Strobe a swap into A and queue the whole frame it must deliver.
   task automatic start_a();
      gtg_a = 1'b1;
      for (int i = 0; i < FL; i++) qa.push_back('{d: mem_a[i], l: (i == FL - 1)});
      tick();
      gtg_a = 1'b0;
   endtask

   task automatic wait_idle_a(input string name);
      int n = 0;
      while (!(rdone_a && qa.size() == 0) && n < 4000) begin tick(); n++; end
      chk(name, (n < 4000), 1'b1);
   endtask

   task automatic wait_beats_a(input int target, input string name);
      int n = 0;
      while (beats_a < target && n < 4000) begin tick(); n++; end
      chk(name, (n < 4000), 1'b1);
   endtask

   initial begin
      bit ok;
      int t0, n;
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int t0, n;
      for (int i = 0; i < FL; i++) mem_a[i] = DW'(i * 3);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < FLB; i++) bank_b[k][i] = DW'(100 * (k + 1) + i);

      // Reset held with random inputs
      ready_mode_a = 1;
      repeat (6) begin
         tick();
         gtg_a = 1'($urandom_range(0, 1));
         gtg_b = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("rst_read_done", rdone_a, 1'b1);
      chk("rst_valid", mvalid_a, 1'b0);
      chk("rst_raddr", raddr_a, '0);
      chk("rst_err", err_a, 1'b0);
      chk("rst_last", mlast_a, 1'b0);
      chk("rst_data", mdata_a, '0);
      ready_mode_a = 0;
      tick();
      gtg_a = 1'b0; gtg_b = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();

      // Single frame, m_ready held high: cycle-exact latency
      start_a();
      @(negedge clk);
      chk("f1_read_done_c1", rdone_a, 1'b0);
      chk("f1_raddr_c1", raddr_a, '0);
      chk("f1_valid_c1", mvalid_a, 1'b0);
      @(negedge clk);
      chk("f1_valid_c2", mvalid_a, 1'b0);
      @(negedge clk);
      chk("f1_valid_c3", mvalid_a, 1'b1);
      ok = 1'b1;
      repeat (FL - 1) begin @(negedge clk); if (!mvalid_a) ok = 1'b0; end
      chk("f1_contiguous", ok, 1'b1);
      @(negedge clk);
      chk("f1_read_done_after", rdone_a, 1'b1);
      chk("f1_valid_after", mvalid_a, 1'b0);
      chk("f1_queue_empty", qa.size(), 0);
      chk("f1_no_err", err_a, 1'b0);
      tick();

      // Backpressure, same frame
      ready_mode_a = 1;
      start_a();
      wait_idle_a("bp_timeout");
      chk("bp_no_err", err_a, 1'b0);

      // Random contents under backpressure
      for (int i = 0; i < FL; i++) mem_a[i] = $urandom;
      start_a();
      wait_idle_a("rnd_timeout");

      // Reset mid-frame at beat 100
      start_a();
      wait_beats_a(100, "mid_reset_reach");
      rst_n = 1'b0;
      qa.delete();
      #1;
      chk("mid_rst_read_done", rdone_a, 1'b1);
      chk("mid_rst_valid", mvalid_a, 1'b0);
      chk("mid_rst_raddr", raddr_a, '0);
      chk("mid_rst_last", mlast_a, 1'b0);
      chk("mid_rst_data", mdata_a, '0);
      repeat (2) tick();
      rst_n = 1'b1;
      ready_mode_a = 0;
      repeat (2) tick();
      start_a();
      @(negedge clk);
      chk("restart_raddr", raddr_a, '0);
      chk("restart_read_done", rdone_a, 1'b0);
      wait_idle_a("restart_timeout");

      // Stray strobe at beat 50
      ready_mode_a = 1;
      t0 = total_a;
      start_a();
      wait_beats_a(50, "stray_reach");
      gtg_a = 1'b1;
      tick();
      gtg_a = 1'b0;
      wait_idle_a("stray_timeout");
      repeat (4) tick();
      chk("stray_total_beats", total_a - t0, FL);
      chk("stray_no_extra", qa.size(), 0);
      chk("stray_read_done", rdone_a, 1'b1);
      chk("stray_err", err_a, EXP_ERR);
      ready_mode_a = 0;
      start_a();
      wait_idle_a("sticky_timeout");
      chk("stray_err_sticky", err_a, EXP_ERR);

      // FRAME_LEN=4, two back-to-back frames from the ping-pong model
      ready_mode_b = 1;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (!rdone_b && n < 500) begin tick(); n++; end
         chk("b_wait_done", (n < 500), 1'b1);
         gtg_b = 1'b1;
         rd_sel_b ^= 1;
         for (int i = 0; i < FLB; i++) qb.push_back('{d: bank_b[rd_sel_b][i], l: (i == FLB - 1)});
         tick();
         gtg_b = 1'b0;
         @(negedge clk);
         chk("b_read_done_c1", rdone_b, 1'b0);
      end
      n = 0;
      while (!(rdone_b && qb.size() == 0) && n < 500) begin tick(); n++; end
      chk("b_idle_timeout", (n < 500), 1'b1);
      chk("b_total_beats", beats_b, 8);
      chk("b_last_positions", last_pos_b, 8'b1000_1000);
      chk("b_read_done_end", rdone_b, 1'b1);
      chk("b_no_err", err_b, 1'b0);

      // Final reset clears the sticky flag
      rst_n = 1'b0;
      #1;
      chk("final_rst_err", err_a, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pingpong_reader.md
Name: pingpong_reader

Overview:
- Read-side engine for the 32x256 ping-pong sample buffer.
- Waits for the buffer's swap strobe, then sweeps the read port through one frame.
- Absorbs the one-cycle RAM read latency and emits each word as a valid/ready stream to downstream DSP (beamforming sum).
- Holds read_done high between frames so the buffer may swap.

Parameters:
- DATA_W, 32, read-data and stream width
- ADDR_W, 8, read-address width
- FRAME_LEN, 256, words per frame; legal range 1..2^ADDR_W
- FIFO_DEPTH, 2, output FIFO entries; minimum 2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- good_to_go  in  1  one-cycle strobe from the buffer: read buffer has just swapped
- r_addr  out  ADDR_W  read address to the buffer (registered)
- r_q  in  DATA_W  read data; valid the cycle after r_addr is presented
- read_done  out  1  high while the reader needs no more reads (registered)
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  marks word FRAME_LEN-1
- err_overrun  out  1  sticky: swap strobe arrived mid-frame

Behaviour:
- Reset values:
  - read_done=1, r_addr=0, m_valid=0, m_last=0, m_data=0, err_overrun=0.
  - FIFO empty, in-flight flag clear, state IDLE.
- Beat: m_valid & m_ready. m_data and m_last are held stable while m_valid & !m_ready.
- State machine:
  - IDLE: read_done=1. On good_to_go, go to READ, clear addr/issue counters, read_done=0 in the next cycle.
  - READ: issue one read per cycle while credit allows. Issue count reaching FRAME_LEN goes to DRAIN.
  - DRAIN: no issues. The beat carrying m_last goes to IDLE, read_done=1 in the next cycle.
- Read credit:
  - Issue is allowed when (fifo_count + in_flight - beat) < FIFO_DEPTH.
  - On issue: r_addr holds the address, in_flight=1 for the next cycle, r_addr increments at the edge.
  - r_q is written into the FIFO only in the cycle when in_flight=1.
  - With m_ready held high this gives one word per cycle.
- Latency:
  - good_to_go sampled at edge 0.
  - r_addr=0 presented in cycle 1.
  - r_q captured at end of cycle 2.
  - First m_valid in cycle 3.
- Arithmetic:
  - Address counter is ADDR_W bits and never wraps within a frame.
  - Issue and beat counters are ADDR_W+1 bits so FRAME_LEN=2^ADDR_W is representable.
  - m_last = beat counter equals FRAME_LEN-1.
- Boundaries:
  - good_to_go in READ or DRAIN: ignored, stream continues, err_overrun set (see Optional Feature).
  - good_to_go coinciding with the m_last beat: treated as mid-frame (ignored and flagged).
  - FRAME_LEN=1: single beat with m_last=1.
  - FIFO full and m_ready low: issue stalls, r_addr holds.
  - rst_n asserted mid-frame: immediate return to reset values, FIFO flushed, the partial frame is abandoned.

Optional Feature:
- Macro PINGPONG_READER_OVERRUN_DET_EN.
- Defined:
  - err_overrun is set by good_to_go in READ/DRAIN.
  - Cleared only by rst_n.
- Undefined:
  - err_overrun is tied to 0 and the detection logic is absent.
  - The stray strobe is still ignored.

Decomposition:
- Package pingpong_pkg:
  - rd_state_t enum {IDLE, READ, DRAIN}
  - Default constants PP_DATA_W=32, PP_ADDR_W=8, PP_FRAME_LEN=256
- One sub-module, pingpong_rd_fifo:
  - Parameterised DATA_W x FIFO_DEPTH synchronous FIFO with count output.
  - Holds data+last; asynchronous active-low reset flushes it.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> read_done=1, m_valid=0, r_addr=0, err_overrun=0.
- Single frame, mem[i]=i*3, m_ready=1, good_to_go at cycle 0:
  - read_done=0 from cycle 1.
  - m_valid from cycle 3, 256 contiguous beats, data 0,3,...,765.
  - m_last only on beat 255.
  - read_done=1 the cycle after.
- Backpressure:
  - m_ready random at 50%, same frame -> exact sequence, no drops or duplicates.
  - m_data stable during stalls.
  - r_addr never exceeds 2 ahead of the last beat.
- Reset mid-frame at beat 100 -> outputs return to reset values.
  - Next good_to_go restarts at r_addr=0.
  - First beat is mem[0].
- Stray strobe: good_to_go at beat 50 -> stream unaffected, 256 beats total; err_overrun=1 and sticky with the macro, 0 without.
- FRAME_LEN=4, two back-to-back frames paired with a ping-pong model -> beats 0..3 twice, m_last on beats 3 and 7, read_done low only during frames.
